div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
Shares one iterative integer divider (internal div_int instance, same WIDTH) among NREQ requesters. Requests are granted round-robin, one at a time. The block sequences the divider's start/busy/valid/dbz protocol, captures its result and returns it on a single response channel tagged with the requester index. It sits between the requesting datapath blocks and the divider.

Parameters:
WIDTH, 4, operand/result width passed to the divider
NREQ, 4, number of requesters (>=2); IDW = $clog2(NREQ)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot grant; request accepted when req_valid[i] & req_ready[i]
req_x  in  NREQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
req_y  in  NREQ*WIDTH  divisors, same packing
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_id  out  IDW  index of served requester
resp_q  out  WIDTH  quotient
resp_r  out  WIDTH  remainder
resp_dbz  out  1  divide-by-zero flag

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- FSM states: IDLE, START, WAIT, RESP. Reset value is IDLE.
- Reset values: resp_valid=0, resp_id=0, resp_q=0, resp_r=0, resp_dbz=0, rr pointer ptr=0, divider start=0. req_ready=0 while rst is high.
- IDLE: req_ready is combinational and one-hot. It selects the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ. It is all-zero if no request or not in IDLE.
- On acceptance, latch id, x and y, and go to START.
- Requester rule: req_valid must not depend on req_ready. x and y must be stable while valid.
- START: drive divider start=1 for exactly one cycle with the latched x and y, then go to WAIT. start=0 in all other states.
- WAIT: from the first WAIT cycle, complete when divider busy=0.
  - If divider valid=1: latch q, r, dbz=0.
  - If divider dbz=1: latch q=0, r=0, dbz=1.
  - Then go to RESP.
- RESP: resp_valid=1. resp_id, q, r and dbz are held stable until resp_ready=1. On the handshake cycle, set ptr = (id+1) mod NREQ and go to IDLE.
- No new grant in the handshake cycle; the earliest next acceptance is the following cycle.
- Latency, with acceptance in cycle T:
  - start high in T+1.
  - Nonzero divisor: resp_valid first high in T+WIDTH+3.
  - Zero divisor: resp_valid first high in T+3.
- Backpressure: resp_valid stays high indefinitely while resp_ready=0. There is no timeout, and all requesters stall.
- Divider state is not reset. The arbiter ignores divider busy, valid and dbz outside WAIT, and every START reinitialises the divider.
- Reset mid-operation (START/WAIT/RESP): the next cycle is IDLE with the reset values above. Any pending divider completion is ignored. The interrupted request is dropped and the requester must re-request.
- Arithmetic: q = x / y, r = x % y, both unsigned WIDTH bits. With y=0, q=r=0 and dbz=1.

Optional Feature:
- Macro DIV_ARB_FAST_EN.
- Defined: requests with y=0 or y=1 bypass the divider. IDLE goes directly to RESP, no start is issued, and resp_valid is high in T+1.
  - y=0 gives q=0, r=0, dbz=1.
  - y=1 gives q=x, r=0, dbz=0.
  - ptr update is as normal.
- Undefined: every request goes through START/WAIT with the latencies above.

Test Plan:
- WIDTH=4, single requester 0: x=13, y=4, resp_ready=1. Response resp_id=0, q=3, r=1, dbz=0, resp_valid first high at T+7.
- Requester 2: x=9, y=0. Response q=0, r=0, dbz=1. Arrival is T+3, or T+1 with DIV_ARB_FAST_EN.
- All four requesters hold valid (x=15, y=i+1). Grant order is 0,1,2,3,0, and resp_q values are 15, 7, 5, 3.
- resp_ready held 0 for 10 cycles in RESP. resp_valid, resp_id, q and r stay stable, req_ready stays all-zero, and the response completes when resp_ready=1.
- rst asserted in WAIT (x=14, y=3), then requester 1 sends x=7, y=2 the cycle after rst drops. The only response is id=1, q=3, r=1, and ptr restarts from 0.
- x=0, y=15 gives q=0, r=0. x=15, y=1 gives q=15, r=0, through the divider when DIV_ARB_FAST_EN is undefined and bypassed (T+1) when it is defined.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider (div_int) among NREQ requesters.
// Optional DIV_ARB_FAST_EN: divisors 0 and 1 bypass the divider and respond the cycle after acceptance.

module div_int #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             valid,
  output logic             dbz,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;

  // Restoring division: q doubles as the dividend shift register, one quotient bit per cycle.
  assign trial = {r, q[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (start) begin
      dvs   <= y;
      r     <= '0;
      valid <= 1'b0;
      if (y == '0) begin
        q    <= '0;
        busy <= 1'b0;
        dbz  <= 1'b1;
        cnt  <= '0;
      end else begin
        q    <= x;
        busy <= 1'b1;
        dbz  <= 1'b0;
        cnt  <= CW'(WIDTH);
      end
    end else if (busy) begin
      if (trial >= {1'b0, dvs}) begin
        r <= WIDTH'(trial - {1'b0, dvs});
        q <= {q[WIDTH-2:0], 1'b1};
      end else begin
        r <= trial[WIDTH-1:0];
        q <= {q[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end
endmodule

module div_arbiter #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_q,
  output logic [WIDTH-1:0]      resp_r,
  output logic                  resp_dbz
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr, id, gidx;
  logic             gfound, acc, bypass;
  int               idx;
  logic [WIDTH-1:0] x_l, y_l, sel_x, sel_y;
  logic             div_start, div_busy, div_valid, div_dbz;
  logic [WIDTH-1:0] div_q, div_r;

  always_comb begin
    gidx   = '0;
    gfound = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gfound && req_valid[idx]) begin
        gfound = 1'b1;
        gidx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && gfound) req_ready[gidx] = 1'b1;
  end

  assign acc   = |(req_valid & req_ready);
  assign sel_x = req_x[gidx*WIDTH +: WIDTH];
  assign sel_y = req_y[gidx*WIDTH +: WIDTH];

`ifdef DIV_ARB_FAST_EN
  assign bypass = (sel_y <= WIDTH'(1));
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      IDLE:  if (acc) state_nx = bypass ? RESP : START;
      START: begin
        div_start = !rst;
        state_nx  = WAIT;
      end
      WAIT:  if (!div_busy) state_nx = RESP;
      RESP:  if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      id       <= '0;
      resp_q   <= '0;
      resp_r   <= '0;
      resp_dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          id <= gidx;
          if (bypass) begin
            resp_q   <= (sel_y == '0) ? '0 : sel_x;
            resp_r   <= '0;
            resp_dbz <= (sel_y == '0);
          end
        end
        WAIT: if (!div_busy) begin
          if (div_dbz) begin
            resp_q   <= '0;
            resp_r   <= '0;
            resp_dbz <= 1'b1;
          end else if (div_valid) begin
            resp_q   <= div_q;
            resp_r   <= div_r;
            resp_dbz <= 1'b0;
          end
        end
        RESP: if (resp_ready) ptr <= IDW'((int'(id) + 1) % NREQ);
        default: ;
      endcase
    end
  end

  // Operands only matter once a grant has been taken, so they carry no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      x_l <= sel_x;
      y_l <= sel_y;
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_id    = id;

  div_int #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .start (div_start),
    .x     (x_l),
    .y     (y_l),
    .busy  (div_busy),
    .valid (div_valid),
    .dbz   (div_dbz),
    .q     (div_q),
    .r     (div_r)
  );
endmodule

// File: tb/tb_div_arbiter.sv
// Randomised bench for div_arbiter against an arithmetic / round-robin reference model.
// Honours DIV_ARB_FAST_EN when computing expected latencies.
module tb_div_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
`ifdef DIV_ARB_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x = '0;
  logic [NREQ*WIDTH-1:0] req_y = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_q, resp_r;
  logic                  resp_dbz;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  int bx[NREQ];
  int by[NREQ];

  div_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_q(resp_q), .resp_r(resp_r), .resp_dbz(resp_dbz)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_res(input int id, input int x, input int y);
    int q, r, d;
    if (y == 0) begin q = 0; r = 0; d = 1; end
    else begin q = x / y; r = x % y; d = 0; end
    return {32'(id), 32'(q), 32'(r), 32'(d)};
  endfunction

  function automatic int exp_lat(input int y);
    if (FAST && y <= 1) return 1;
    if (y == 0) return 3;
    return WIDTH + 3;
  endfunction

  function automatic logic [127:0] dut_res();
    return {32'(resp_id), 32'(resp_q), 32'(resp_r), 32'(resp_dbz)};
  endfunction

  // Lone request, resp_ready held high; lat = -1 when no response shows up.
  task automatic send_one(input int id, input int x, input int y,
                          output int lat, output logic [127:0] got);
    @(negedge clk);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_x[id*WIDTH +: WIDTH] = WIDTH'(x);
    req_y[id*WIDTH +: WIDTH] = WIDTH'(y);
    resp_ready = 1'b1;
    lat = -1;
    got = '1;
    #1;
    if (req_ready[id]) begin
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        if (resp_valid) begin
          lat = n;
          got = dut_res();
          break;
        end
      end
    end
    @(negedge clk);
    req_valid = '0;
    mptr = (id + 1) % NREQ;
  endtask

  // All requesters in mask raise valid together and hold it until granted.
  task automatic run_batch(input logic [NREQ-1:0] mask, input bit rnd_ready, input string tag);
    logic [127:0]    expq[$];
    logic [NREQ-1:0] pend, prev_rdy;
    int              p;
    pend = mask;
    p = mptr;
    while (pend != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (p + k) % NREQ;
        if (pend[i]) begin
          expq.push_back(ref_res(i, bx[i], by[i]));
          pend[i] = 1'b0;
          p = (i + 1) % NREQ;
          break;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*WIDTH +: WIDTH] = WIDTH'(bx[i]);
      req_y[i*WIDTH +: WIDTH] = WIDTH'(by[i]);
    end
    req_valid = mask;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 2000 && expq.size() > 0; cyc++) begin
      #1;
      prev_rdy = req_ready;
      if (resp_valid && resp_ready) begin
        checks++;
        if (dut_res() !== expq[0]) begin
          errors++;
          $display("FAIL %s_resp got %h exp %h", tag, dut_res(), expq[0]);
        end
        mptr = (int'(expq[0][127:96]) + 1) % NREQ;
        void'(expq.pop_front());
      end
      @(negedge clk);
      req_valid = req_valid & ~prev_rdy;
      resp_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending exp 0", tag, expq.size());
    end
    req_valid = '0;
    resp_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    #1;
    checks++;
    if ({resp_valid, req_ready, resp_id, resp_q, resp_r, resp_dbz} !== '0) begin
      errors++;
      $display("FAIL reset got %b exp 0", {resp_valid, req_ready, resp_id, resp_q, resp_r, resp_dbz});
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_all_four();
    for (int i = 0; i < NREQ; i++) begin bx[i] = 15; by[i] = i + 1; end
    run_batch('1, 1'b0, "all_four");
  endtask

  task automatic test_single();
    int lat; logic [127:0] got;
    send_one(0, 13, 4, lat, got);
    checks++;
    if (lat !== exp_lat(4)) begin errors++; $display("FAIL single_lat got %0d exp %0d", lat, exp_lat(4)); end
    checks++;
    if (got !== ref_res(0, 13, 4)) begin errors++; $display("FAIL single_res got %h exp %h", got, ref_res(0, 13, 4)); end
  endtask

  task automatic test_dbz();
    int lat; logic [127:0] got;
    send_one(2, 9, 0, lat, got);
    checks++;
    if (lat !== exp_lat(0)) begin errors++; $display("FAIL dbz_lat got %0d exp %0d", lat, exp_lat(0)); end
    checks++;
    if (got !== ref_res(2, 9, 0)) begin errors++; $display("FAIL dbz_res got %h exp %h", got, ref_res(2, 9, 0)); end
  endtask

  task automatic test_edges();
    int lat; logic [127:0] got;
    send_one(1, 0, 15, lat, got);
    checks++;
    if ({lat, got} !== {exp_lat(15), ref_res(1, 0, 15)}) begin
      errors++; $display("FAIL edge_zero_x got %0d %h exp %0d %h", lat, got, exp_lat(15), ref_res(1, 0, 15));
    end
    send_one(3, 15, 1, lat, got);
    checks++;
    if ({lat, got} !== {exp_lat(1), ref_res(3, 15, 1)}) begin
      errors++; $display("FAIL edge_div1 got %0d %h exp %0d %h", lat, got, exp_lat(1), ref_res(3, 15, 1));
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_x[1*WIDTH +: WIDTH] = 4'd11; req_y[1*WIDTH +: WIDTH] = 4'd3;
    req_x[2*WIDTH +: WIDTH] = 4'd8;  req_y[2*WIDTH +: WIDTH] = 4'd2;
    req_valid = 4'b0010;
    resp_ready = 1'b0;
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      if (resp_valid) begin n = c; break; end
    end
    checks++;
    if (n !== exp_lat(3)) begin errors++; $display("FAIL bp_lat got %0d exp %0d", n, exp_lat(3)); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({resp_valid, req_ready, dut_res()} !== {1'b1, 4'b0000, ref_res(1, 11, 3)}) begin
        errors++;
        $display("FAIL bp_hold got %b %b %h exp 1 0000 %h", resp_valid, req_ready, dut_res(), ref_res(1, 11, 3));
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    checks++;
    if ({resp_valid, req_ready} !== 5'b1_0000) begin
      errors++; $display("FAIL bp_hs_cycle got %b exp 10000", {resp_valid, req_ready});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({resp_valid, req_ready} !== 5'b0_0100) begin
      errors++; $display("FAIL bp_next_grant got %b exp 00100", {resp_valid, req_ready});
    end
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (resp_valid) begin n = c; break; end
    end
    checks++;
    if ({n, dut_res()} !== {exp_lat(2), ref_res(2, 8, 2)}) begin
      errors++; $display("FAIL bp_second got %0d %h exp %0d %h", n, dut_res(), exp_lat(2), ref_res(2, 8, 2));
    end
    @(negedge clk);
    mptr = 3;
  endtask

  task automatic test_reset_mid();
    int n, ghosts;
    @(negedge clk);
    req_x[3*WIDTH +: WIDTH] = 4'd14; req_y[3*WIDTH +: WIDTH] = 4'd3;
    req_valid = 4'b1000;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_x[1*WIDTH +: WIDTH] = 4'd7; req_y[1*WIDTH +: WIDTH] = 4'd2;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({resp_valid, req_ready} !== 5'b0_0010) begin
      errors++; $display("FAIL rst_regrant got %b exp 00010", {resp_valid, req_ready});
    end
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (resp_valid) begin n = c; break; end
    end
    checks++;
    if ({n, dut_res()} !== {exp_lat(2), ref_res(1, 7, 2)}) begin
      errors++; $display("FAIL rst_resp got %0d %h exp %0d %h", n, dut_res(), exp_lat(2), ref_res(1, 7, 2));
    end
    ghosts = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid) ghosts++;
    end
    checks++;
    if (ghosts !== 0) begin errors++; $display("FAIL rst_ghost got %0d exp 0", ghosts); end
    // ptr is now 2; after a reset requester 1 must win over 3 again.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    bx[1] = 12; by[1] = 5; bx[3] = 10; by[3] = 3;
    run_batch(4'b1010, 1'b0, "rr_after_rst");
  endtask

  task automatic test_random();
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        bx[i] = $urandom_range(0, 15);
        by[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 15);
      end
      run_batch(NREQ'($urandom_range(1, 15)), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_dbz();
    test_edges();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
